// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
// Loads a byte serially (MSB first) into an external 8-bit shift register,
// then reads it back one tap at a time through an external 8:1 mux and
// reports whether the reassembled byte matches what was loaded.
// Sequence: IDLE -> CLEAR -> SHIFT(8) -> [SETTLE(SETTLE_CYC)] -> READ(8) -> RESP.

module shift_reg_sequencer #(
   parameter int SETTLE_CYC = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_data,
   input  logic       abort,
   output logic       sr_clr_n,
   output logic       sr_shift_en,
   output logic [7:0] sr_data_in,
   output logic [2:0] sr_sel,
   input  logic       sr_tap,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_mismatch,
   output logic       busy,
   output logic [7:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      SETTLE,
      READ,
      RESP
   } state_t;

   // With no settle time SHIFT goes straight to READ; otherwise the settle
   // counter is loaded with SETTLE_CYC-1 and counts down to zero.
   localparam bit         HAS_SETTLE  = (SETTLE_CYC > 0);
   localparam logic [3:0] SETTLE_LAST = HAS_SETTLE ? 4'(SETTLE_CYC - 1) : 4'd0;

   state_t     state;
   state_t     state_next;
   logic [7:0] data_q;
   logic [2:0] bit_cnt;
   logic [3:0] settle_cnt;
   logic       handshake;

   // A response is consumed only when abort is not competing with it
   assign handshake = (state == RESP) && rsp_ready && !abort;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and all state-derived outputs
   always_comb begin
      state_next   = state;
      req_ready    = 1'b0;
      busy         = 1'b1;
      sr_clr_n     = 1'b1;
      sr_shift_en  = 1'b0;
      sr_data_in   = 8'h00;
      sr_sel       = 3'd0;
      rsp_valid    = 1'b0;
      rsp_mismatch = 1'b0;

      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_next = CLEAR;
            end
         end

         CLEAR: begin
            sr_clr_n   = 1'b0;
            state_next = SHIFT;
         end

         SHIFT: begin
            sr_shift_en = 1'b1;
            sr_data_in  = {7'b0000000, data_q[3'd7 - bit_cnt]};
            if (bit_cnt == 3'd7) begin
               state_next = HAS_SETTLE ? SETTLE : READ;
            end
         end

         SETTLE: begin
            if (settle_cnt == 4'd0) begin
               state_next = READ;
            end
         end

         READ: begin
            sr_sel = bit_cnt;
            if (bit_cnt == 3'd7) begin
               state_next = RESP;
            end
         end

         RESP: begin
            rsp_valid    = 1'b1;
            rsp_mismatch = (rsp_data != data_q);
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort && (state != IDLE)) begin
         state_next = IDLE;
      end
   end

   // Request latch, bit/settle counters and readback assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= 8'h00;
         bit_cnt    <= 3'd0;
         settle_cnt <= 4'd0;
         rsp_data   <= 8'h00;
      end else begin
         if ((state == IDLE) && req_valid) begin
            data_q <= req_data;
         end

         if (abort && (state != IDLE)) begin
            bit_cnt <= 3'd0;
         end else if ((state == SHIFT) || (state == READ)) begin
            bit_cnt <= bit_cnt + 3'd1;
         end else begin
            bit_cnt <= 3'd0;
         end

         if (state == SHIFT) begin
            settle_cnt <= SETTLE_LAST;
         end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
         end

         if (state == READ) begin
            rsp_data[bit_cnt] <= sr_tap;
         end
      end
   end

   // Saturating count of consumed responses that reported a mismatch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'h00;
      end else if (handshake && rsp_mismatch && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'h01;
      end
   end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer
// Two sequencers (SETTLE_CYC=0 and SETTLE_CYC=3) each drive their own
// behavioural shift register + 8:1 mux with an optional stuck tap. One is
// active at a time (sel3); inputs of the other are held at zero.

module tb_shift_reg_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       abort;
   logic       rsp_ready;
   logic [7:0] req_data;
   logic       sel3;

   logic       fault_en;
   logic [2:0] fault_bit;
   logic       fault_val;

   int vectors     = 0;
   int miscompares = 0;
   int cur_edge    = 0;
   int model_err[2] = '{0, 0};

   logic       d0_req_ready, d0_sr_clr_n, d0_sr_shift_en, d0_rsp_valid, d0_rsp_mismatch, d0_busy, d0_tap;
   logic [7:0] d0_sr_data_in, d0_rsp_data, d0_err_cnt;
   logic [2:0] d0_sr_sel;
   logic [7:0] q0 = 8'h00;

   logic       d3_req_ready, d3_sr_clr_n, d3_sr_shift_en, d3_rsp_valid, d3_rsp_mismatch, d3_busy, d3_tap;
   logic [7:0] d3_sr_data_in, d3_rsp_data, d3_err_cnt;
   logic [2:0] d3_sr_sel;
   logic [7:0] q3 = 8'h00;

   logic       o_req_ready, o_sr_clr_n, o_sr_shift_en, o_rsp_valid, o_rsp_mismatch, o_busy;
   logic [7:0] o_sr_data_in, o_rsp_data, o_err_cnt, o_q;
   logic [2:0] o_sr_sel;

   // Free-running clock
   always #5 clk = ~clk;

   shift_reg_sequencer #(.SETTLE_CYC(0)) dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid & ~sel3),
      .req_ready    (d0_req_ready),
      .req_data     (req_data),
      .abort        (abort & ~sel3),
      .sr_clr_n     (d0_sr_clr_n),
      .sr_shift_en  (d0_sr_shift_en),
      .sr_data_in   (d0_sr_data_in),
      .sr_sel       (d0_sr_sel),
      .sr_tap       (d0_tap),
      .rsp_valid    (d0_rsp_valid),
      .rsp_ready    (rsp_ready & ~sel3),
      .rsp_data     (d0_rsp_data),
      .rsp_mismatch (d0_rsp_mismatch),
      .busy         (d0_busy),
      .err_cnt      (d0_err_cnt)
   );

   shift_reg_sequencer #(.SETTLE_CYC(3)) dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid & sel3),
      .req_ready    (d3_req_ready),
      .req_data     (req_data),
      .abort        (abort & sel3),
      .sr_clr_n     (d3_sr_clr_n),
      .sr_shift_en  (d3_sr_shift_en),
      .sr_data_in   (d3_sr_data_in),
      .sr_sel       (d3_sr_sel),
      .sr_tap       (d3_tap),
      .rsp_valid    (d3_rsp_valid),
      .rsp_ready    (rsp_ready & sel3),
      .rsp_data     (d3_rsp_data),
      .rsp_mismatch (d3_rsp_mismatch),
      .busy         (d3_busy),
      .err_cnt      (d3_err_cnt)
   );

   // External shift registers: sync active-low clear, shift toward the MSB
   always @(posedge clk) begin
      if (!d0_sr_clr_n) q0 <= 8'h00;
      else if (d0_sr_shift_en) q0 <= {q0[6:0], d0_sr_data_in[0]};
      if (!d3_sr_clr_n) q3 <= 8'h00;
      else if (d3_sr_shift_en) q3 <= {q3[6:0], d3_sr_data_in[0]};
   end

   assign d0_tap = (fault_en && (d0_sr_sel == fault_bit)) ? fault_val : q0[d0_sr_sel];
   assign d3_tap = (fault_en && (d3_sr_sel == fault_bit)) ? fault_val : q3[d3_sr_sel];

   assign o_req_ready    = sel3 ? d3_req_ready    : d0_req_ready;
   assign o_sr_clr_n     = sel3 ? d3_sr_clr_n     : d0_sr_clr_n;
   assign o_sr_shift_en  = sel3 ? d3_sr_shift_en  : d0_sr_shift_en;
   assign o_sr_data_in   = sel3 ? d3_sr_data_in   : d0_sr_data_in;
   assign o_sr_sel       = sel3 ? d3_sr_sel       : d0_sr_sel;
   assign o_rsp_valid    = sel3 ? d3_rsp_valid    : d0_rsp_valid;
   assign o_rsp_data     = sel3 ? d3_rsp_data     : d0_rsp_data;
   assign o_rsp_mismatch = sel3 ? d3_rsp_mismatch : d0_rsp_mismatch;
   assign o_busy         = sel3 ? d3_busy         : d0_busy;
   assign o_err_cnt      = sel3 ? d3_err_cnt      : d0_err_cnt;
   assign o_q            = sel3 ? q3              : q0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (settle=%0d edge=%0d): got 0x%0h, expected 0x%0h",
                  tag, sel3 ? 3 : 0, cur_edge, got, exp);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_req_ready", o_req_ready, 1);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_rsp_valid", o_rsp_valid, 0);
      checkOutput("rst_rsp_data", o_rsp_data, 0);
      checkOutput("rst_rsp_mismatch", o_rsp_mismatch, 0);
      checkOutput("rst_err_cnt", o_err_cnt, 0);
      checkOutput("rst_sr_clr_n", o_sr_clr_n, 1);
      checkOutput("rst_sr_shift_en", o_sr_shift_en, 0);
      checkOutput("rst_sr_sel", o_sr_sel, 0);
      checkOutput("rst_sr_data_in", o_sr_data_in, 0);
   endtask

   // One request on the active DUT; abort_at=0 means no abort, otherwise abort
   // is high in the cycle ending at edge abort_at (edges counted from acceptance)
   task automatic applyStimulus(input logic [7:0] data, input int hold, input int abort_at);
      int s, lat, idx;
      logic [7:0] exp_data;
      logic exp_mm;
      s   = sel3 ? 3 : 0;
      lat = 17 + s;
      idx = sel3 ? 1 : 0;
      exp_data = data;
      if (fault_en) exp_data[fault_bit] = fault_val;
      exp_mm = (exp_data != data);
      cur_edge = 0;

      @(negedge clk);
      checkOutput("req_ready_idle", o_req_ready, 1);
      checkOutput("busy_idle", o_busy, 0);
      req_valid = 1'b1;
      req_data  = data;
      abort     = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("clr_n_clear", o_sr_clr_n, 0);
      checkOutput("busy_clear", o_busy, 1);
      checkOutput("req_ready_busy", o_req_ready, 0);
      checkOutput("shift_en_clear", o_sr_shift_en, 0);

      for (int e = 1; e <= lat + hold + 1; e++) begin
         abort     = (e == abort_at);
         req_valid = 1'($urandom_range(0, 1));
         req_data  = 8'($urandom_range(0, 255));
         rsp_ready = (e <= lat) ? 1'($urandom_range(0, 1)) : (e == lat + hold + 1);
         @(negedge clk);
         cur_edge = e;

         if ((abort_at != 0) && (e >= abort_at)) begin
            req_valid = 1'b0;
            abort     = 1'b0;
            rsp_ready = 1'b0;
            checkOutput("busy_after_abort", o_busy, 0);
            checkOutput("ready_after_abort", o_req_ready, 1);
            checkOutput("err_after_abort", o_err_cnt, model_err[idx]);
            repeat (3) begin
               @(negedge clk);
               checkOutput("no_rsp_after_abort", o_rsp_valid, 0);
            end
            return;
         end

         checkOutput("shift_en", o_sr_shift_en, e <= 8);
         if (e <= 8) checkOutput("sr_data_in", o_sr_data_in, (data >> (8 - e)) & 8'h01);
         else checkOutput("sr_data_in_hi", o_sr_data_in[7:1], 0);
         checkOutput("sr_sel", o_sr_sel, ((e >= 9 + s) && (e <= 16 + s)) ? (e - 9 - s) : 0);
         checkOutput("sr_clr_n", o_sr_clr_n, 1);
         if (e == 9) checkOutput("ext_reg_loaded", o_q, data);

         if (e <= lat + hold) begin
            checkOutput("rsp_valid", o_rsp_valid, e >= lat);
            checkOutput("busy_op", o_busy, 1);
            if (e >= lat) begin
               checkOutput("rsp_data", o_rsp_data, exp_data);
               checkOutput("rsp_mismatch", o_rsp_mismatch, exp_mm);
            end
         end else begin
            req_valid = 1'b0;
            rsp_ready = 1'b0;
            if (exp_mm && (model_err[idx] < 255)) model_err[idx]++;
            checkOutput("rsp_valid_done", o_rsp_valid, 0);
            checkOutput("busy_done", o_busy, 0);
            checkOutput("err_cnt", o_err_cnt, model_err[idx]);
         end
      end
      req_valid = 1'b0;
      abort     = 1'b0;
      rsp_ready = 1'b0;
   endtask

   // Reset pulse in the middle of READ on the SETTLE_CYC=0 DUT
   task automatic resetDuringRead();
      cur_edge = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      req_valid = 1'b0;
      repeat (12) @(negedge clk);
      cur_edge = 12;
      checkOutput("sel_mid_read", o_sr_sel, 3);
      #2 rst_n = 1'b0;
      #1;
      checkResetValues();
      model_err = '{0, 0};
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         checkOutput("no_rsp_after_reset", o_rsp_valid, 0);
      end
   endtask

   initial begin
      int hold, lat, abort_at;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      abort     = 1'b0;
      rsp_ready = 1'b0;
      req_data  = 8'h00;
      sel3      = 1'b0;
      fault_en  = 1'b0;
      fault_bit = 3'd0;
      fault_val = 1'b0;

      #13;
      checkResetValues();
      sel3 = 1'b1;
      checkResetValues();
      sel3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(8'hA5, 0, 0);
      sel3 = 1'b1;
      applyStimulus(8'h3C, 2, 0);

      sel3 = 1'b0;
      fault_en  = 1'b1;
      fault_bit = 3'd4;
      fault_val = 1'b0;
      applyStimulus(8'hFF, 5, 0);
      checkOutput("err_after_stuck4", o_err_cnt, 1);

      fault_en = 1'b0;
      applyStimulus(8'h5A, 0, 5);
      applyStimulus(8'h0F, 0, 0);

      fault_en  = 1'b1;
      fault_bit = 3'd2;
      fault_val = 1'b1;
      applyStimulus(8'h00, 1, 19);
      checkOutput("err_abort_vs_ready", o_err_cnt, 1);

      for (int n = 0; n < 40; n++) begin
         sel3      = 1'($urandom_range(0, 1));
         fault_en  = ($urandom_range(0, 2) == 0);
         fault_bit = 3'($urandom_range(0, 7));
         fault_val = 1'($urandom_range(0, 1));
         hold      = $urandom_range(0, 4);
         lat       = 17 + (sel3 ? 3 : 0);
         abort_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + hold + 1) : 0;
         applyStimulus(8'($urandom_range(0, 255)), hold, abort_at);
      end

      sel3     = 1'b0;
      fault_en = 1'b0;
      resetDuringRead();
      applyStimulus(8'hC3, 0, 0);

      fault_en  = 1'b1;
      fault_bit = 3'd0;
      fault_val = 1'b1;
      for (int n = 0; n < 256; n++) begin
         applyStimulus(8'($urandom_range(0, 255)) & 8'hFE, 0, 0);
      end
      checkOutput("err_saturated", o_err_cnt, 255);
      applyStimulus(8'h10, 0, 0);
      checkOutput("err_stays_saturated", o_err_cnt, 255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
